// File: rtl/jtag_dmi_tap.sv
// JTAG TAP controller with RISC-V DTM (IDCODE, DTMCS, DMIACCESS, BYPASS).
// Optional macro JTAG_DMI_TAP_HARDRESET_EN enables DTMCS dmihardreset.
module jtag_dmi_tap #(
   parameter int unsigned IrLength    = 5,
   parameter logic [31:0] IdcodeValue = 32'h0000_0001,
   parameter int unsigned AbitsWidth  = 7
) (
   input  logic                  jtag_tck_i,
   input  logic                  jtag_trst_ni,
   input  logic                  jtag_tms_i,
   input  logic                  jtag_tdi_i,
   output logic                  jtag_tdo_o,
   output logic                  jtag_tdo_oe_o,
   output logic                  dmi_req_valid_o,
   input  logic                  dmi_req_ready_i,
   output logic [AbitsWidth-1:0] dmi_req_addr_o,
   output logic [31:0]           dmi_req_data_o,
   output logic [1:0]            dmi_req_op_o,
   input  logic                  dmi_resp_valid_i,
   output logic                  dmi_resp_ready_o,
   input  logic [31:0]           dmi_resp_data_i,
   input  logic [1:0]            dmi_resp_resp_i
);

   localparam int unsigned DrW = AbitsWidth + 34;

   localparam logic [IrLength-1:0] IrIdcode = IrLength'(5'h01);
   localparam logic [IrLength-1:0] IrDtmcs  = IrLength'(5'h10);
   localparam logic [IrLength-1:0] IrDmi    = IrLength'(5'h11);
   localparam logic [IrLength-1:0] IrCap    = IrLength'(5'b00101);

   typedef enum logic [3:0] {
      TLR, RTI,
      SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
      SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
   } tap_e;

   typedef enum logic [1:0] {
      SEL_BYPASS, SEL_IDCODE, SEL_DTMCS, SEL_DMI
   } dr_sel_e;

   typedef enum logic [1:0] {
      T_IDLE, T_REQ, T_WAIT
   } txn_e;

   tap_e                  tap;
   dr_sel_e               dr_sel;
   txn_e                  txn;
   logic [IrLength-1:0]   ir;
   logic [IrLength-1:0]   ir_shift;
   logic [DrW-1:0]        dr_shift;
   logic [1:0]            sticky;
   logic [31:0]           last_data;
   logic [31:0]           dtmcs_val;
   logic                  busy;
   logic                  cap_dmi;
   logic                  upd_dmi;
   logic                  upd_dtmcs;
   logic                  launch_op;

   assign busy      = (txn != T_IDLE);
   assign cap_dmi   = (tap == CAP_DR) && (dr_sel == SEL_DMI);
   assign upd_dmi   = (tap == UPD_DR) && (dr_sel == SEL_DMI);
   assign upd_dtmcs = (tap == UPD_DR) && (dr_sel == SEL_DTMCS);
   assign launch_op = (dr_shift[1:0] == 2'd1) || (dr_shift[1:0] == 2'd2);

   // version 1, abits, dmistat = sticky, idle 1; reset bits read 0
   assign dtmcs_val = {14'd0, 1'b0, 1'b0, 1'b0, 3'd1, sticky,
                       6'(AbitsWidth), 4'd1};

   // 16-state TAP controller stepped by TMS
   always_ff @(posedge jtag_tck_i or negedge jtag_trst_ni) begin
      if (!jtag_trst_ni) begin
         tap <= TLR;
      end else begin
         unique case (tap)
            TLR:      tap <= jtag_tms_i ? TLR      : RTI;
            RTI:      tap <= jtag_tms_i ? SEL_DR   : RTI;
            SEL_DR:   tap <= jtag_tms_i ? SEL_IR   : CAP_DR;
            CAP_DR:   tap <= jtag_tms_i ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: tap <= jtag_tms_i ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: tap <= jtag_tms_i ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: tap <= jtag_tms_i ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: tap <= jtag_tms_i ? UPD_DR   : SHIFT_DR;
            UPD_DR:   tap <= jtag_tms_i ? SEL_DR   : RTI;
            SEL_IR:   tap <= jtag_tms_i ? TLR      : CAP_IR;
            CAP_IR:   tap <= jtag_tms_i ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: tap <= jtag_tms_i ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: tap <= jtag_tms_i ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: tap <= jtag_tms_i ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: tap <= jtag_tms_i ? UPD_IR   : SHIFT_IR;
            UPD_IR:   tap <= jtag_tms_i ? SEL_DR   : RTI;
         endcase
      end
   end

   // Instruction register capture, shift and commit
   always_ff @(posedge jtag_tck_i or negedge jtag_trst_ni) begin
      if (!jtag_trst_ni) begin
         ir       <= IrIdcode;
         ir_shift <= '0;
      end else begin
         unique case (1'b1)
            tap == TLR:      ir       <= IrIdcode;
            tap == CAP_IR:   ir_shift <= IrCap;
            tap == SHIFT_IR: ir_shift <= {jtag_tdi_i, ir_shift[IrLength-1:1]};
            tap == UPD_IR:   ir       <= ir_shift;
            default: ;
         endcase
      end
   end

   // Unknown instructions fall back to BYPASS
   always_comb begin
      dr_sel = SEL_BYPASS;
      unique case (1'b1)
         ir == IrIdcode: dr_sel = SEL_IDCODE;
         ir == IrDtmcs:  dr_sel = SEL_DTMCS;
         ir == IrDmi:    dr_sel = SEL_DMI;
         default:        dr_sel = SEL_BYPASS;
      endcase
   end

   // Shared DR shifter; length follows the selected register
   always_ff @(posedge jtag_tck_i or negedge jtag_trst_ni) begin
      if (!jtag_trst_ni) begin
         dr_shift <= '0;
      end else if (tap == CAP_DR) begin
         unique case (dr_sel)
            SEL_IDCODE: dr_shift <= DrW'(IdcodeValue);
            SEL_DTMCS:  dr_shift <= DrW'(dtmcs_val);
            SEL_DMI:    dr_shift <= {dmi_req_addr_o, last_data,
                                     busy ? 2'd3 : sticky};
            SEL_BYPASS: dr_shift <= '0;
         endcase
      end else if (tap == SHIFT_DR) begin
         unique case (dr_sel)
            SEL_DMI:
               dr_shift <= {jtag_tdi_i, dr_shift[DrW-1:1]};
            SEL_IDCODE, SEL_DTMCS:
               dr_shift <= {dr_shift[DrW-1:32], jtag_tdi_i, dr_shift[31:1]};
            SEL_BYPASS:
               dr_shift <= {dr_shift[DrW-1:1], jtag_tdi_i};
         endcase
      end
   end

   // TDO and its enable launch on the falling edge
   always_ff @(negedge jtag_tck_i or negedge jtag_trst_ni) begin
      if (!jtag_trst_ni) begin
         jtag_tdo_o    <= 1'b0;
         jtag_tdo_oe_o <= 1'b0;
      end else begin
         jtag_tdo_oe_o <= (tap == SHIFT_IR) || (tap == SHIFT_DR);
         unique case (1'b1)
            tap == SHIFT_IR: jtag_tdo_o <= ir_shift[0];
            tap == SHIFT_DR: jtag_tdo_o <= dr_shift[0];
            default:         jtag_tdo_o <= 1'b0;
         endcase
      end
   end

   // DMI transaction FSM plus sticky error bookkeeping
   always_ff @(posedge jtag_tck_i or negedge jtag_trst_ni) begin
      if (!jtag_trst_ni) begin
         txn              <= T_IDLE;
         dmi_req_valid_o  <= 1'b0;
         dmi_req_addr_o   <= '0;
         dmi_req_data_o   <= '0;
         dmi_req_op_o     <= '0;
         dmi_resp_ready_o <= 1'b0;
         sticky           <= '0;
         last_data        <= '0;
      end else begin
         case (txn)
            T_IDLE: begin
               if (upd_dmi && sticky == 2'd0 && launch_op) begin
                  dmi_req_addr_o  <= dr_shift[DrW-1:34];
                  dmi_req_data_o  <= dr_shift[33:2];
                  dmi_req_op_o    <= dr_shift[1:0];
                  dmi_req_valid_o <= 1'b1;
                  txn             <= T_REQ;
               end
            end
            T_REQ: begin
               if (dmi_req_ready_i) begin
                  dmi_req_valid_o  <= 1'b0;
                  dmi_resp_ready_o <= 1'b1;
                  txn              <= T_WAIT;
               end
            end
            T_WAIT: begin
               if (dmi_resp_valid_i) begin
                  last_data        <= dmi_resp_data_i;
                  dmi_resp_ready_o <= 1'b0;
                  txn              <= T_IDLE;
                  if (dmi_resp_resp_i == 2'd2) sticky <= 2'd2;
               end
            end
            default: begin
               dmi_req_valid_o  <= 1'b0;
               dmi_resp_ready_o <= 1'b0;
               txn              <= T_IDLE;
            end
         endcase
         // A DMI scan that overlaps a transaction reports busy
         if ((cap_dmi || upd_dmi) && busy) sticky <= 2'd3;
         if (upd_dtmcs && dr_shift[16]) sticky <= 2'd0;
`ifdef JTAG_DMI_TAP_HARDRESET_EN
         if (upd_dtmcs && dr_shift[17]) begin
            txn              <= T_IDLE;
            dmi_req_valid_o  <= 1'b0;
            dmi_resp_ready_o <= 1'b0;
            sticky           <= 2'd0;
            last_data        <= '0;
         end
`endif
      end
   end

endmodule
